tape_player: RTL and testbench
==============================

TAPE_PLAYER -- requirements
Module: tape_player

Interface
REQ-001 SHALL have parameter CE_PER_SAMPLE, default 136, giving the number of ce ticks per CSW sample unit (44.1 kHz from the 6 MHz enable).
REQ-002 SHALL have port clk_sys  in  1  system clock; single clock domain; all logic on posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ce  in  1  timebase enable, one clk_sys cycle wide.
REQ-005 SHALL have port play  in  1  level; 1 = run, 0 = pause.
REQ-006 SHALL have port rewind  in  1  pulse; returns the player to the start of the image.
REQ-007 SHALL have port buff_size  in  20  image length in bytes; sampled continuously.
REQ-008 SHALL have port buff_addr  out  20  byte address of the current read.
REQ-009 SHALL have port buff_rd  out  1  read request; held until buff_ready.
REQ-010 SHALL have port buff_ready  in  1  one-cycle acknowledge; buff_din is valid in the same cycle.
REQ-011 SHALL have port buff_din  in  8  read data.
REQ-012 SHALL have port tape_out  out  1  EAR level; feeds the ASIC tape_in bit.
REQ-013 SHALL have port active  out  1  high in FETCH, EXT and RUN.
REQ-014 SHALL have port done  out  1  high in DONE.

Function
REQ-015 SHALL decode CSW v1 pulse data: a nonzero byte N is a pulse of N samples; byte 0 is followed by a 32-bit little-endian sample count.
REQ-016 SHALL implement states IDLE, FETCH, EXT (4 sub-steps), RUN and DONE.
REQ-017 IDLE: on the first cycle with play=1, if buff_size=0 SHALL go to DONE, else SHALL go to FETCH with buff_addr=0.
REQ-018 FETCH/EXT: SHALL assert buff_rd with a stable buff_addr until buff_ready, then latch buff_din and increment buff_addr by 1.
REQ-019 FETCH byte nonzero: SHALL load the 32-bit count with N and enter RUN on the next cycle.
REQ-020 FETCH byte zero: SHALL enter EXT and read 4 bytes LSB-first into the count, then enter RUN.
REQ-021 If buff_addr reaches buff_size before an EXT read, SHALL go to DONE without a toggle.
REQ-022 An extended count of 0 SHALL skip the pulse: no toggle, next byte fetched.
REQ-023 SHALL run a divider of 0..CE_PER_SAMPLE-1, advanced by ce, in FETCH, EXT and RUN; a divider wrap is a sample tick.
REQ-024 A sample tick during FETCH/EXT SHALL set a pending flag; on count load, the loaded value SHALL be count-1 when the flag is set (minimum 1), and the flag SHALL clear.
REQ-025 RUN: each sample tick SHALL decrement the count.
REQ-026 When the count goes 1->0 in RUN, SHALL toggle tape_out in that same cycle (zero extra latency).
REQ-027 After a toggle, SHALL go to FETCH if buff_addr < buff_size, else to DONE.
REQ-028 DONE SHALL hold tape_out; DONE SHALL exit only via rewind or reset.
REQ-029 play=0 SHALL freeze the divider, count and state.
REQ-030 While play=0, an outstanding buff_rd SHALL still complete and latch its data; no new request SHALL issue until play=1.
REQ-031 rewind SHALL abort any state to IDLE: buff_addr=0, tape_out=0, divider=0, pending cleared.
REQ-032 A rewind during an outstanding read SHALL drop buff_rd and discard the data.
REQ-033 rewind SHALL take priority over a same-cycle ce, buff_ready or play.
REQ-034 Count arithmetic SHALL be 32-bit unsigned; the divider SHALL be clog2(CE_PER_SAMPLE) bits and wrap without overflow.

Reset
REQ-035 On reset assertion, asynchronously: state=IDLE, buff_addr=0, buff_rd=0, tape_out=0, active=0, done=0, divider=0, count=0, pending=0.
REQ-036 After reset release, SHALL stay in IDLE until play=1.

Verification
REQ-037 Image {02,03}, CE_PER_SAMPLE=4, ce every cycle, ready one cycle after rd -> tape_out toggles to 1 after 8 ce ticks from start, to 0 after 12 more; then done=1 and active=0.
REQ-038 Image {00,10,27,00,00} -> 10000 samples, then one toggle, then DONE; image {00,00,00,00,00} -> DONE with no toggle.
REQ-039 Image {00,05} (truncated) -> no toggle; DONE after the read at address 1.
REQ-040 play dropped mid-RUN for 100 cycles -> toggle edge delayed by exactly 100 cycles versus the uninterrupted run; play dropped with buff_rd pending -> read completes, no new rd issues.
REQ-041 rewind asserted while buff_rd is high, same cycle as buff_ready -> IDLE, buff_addr=0, tape_out=0, latched byte ignored; replay reproduces the original toggle timing.
REQ-042 buff_size=0 with play=1 -> DONE on the next cycle, no buff_rd ever.

Source files
------------

// File: rtl/tape_player.sv
// CSW v1 tape player: walks a pulse image in a byte buffer and toggles the EAR
// level at the end of every pulse, timed in sample units derived from ce.
module tape_player #(
   parameter int unsigned CE_PER_SAMPLE = 136
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce,
   input  logic        play,
   input  logic        rewind,
   input  logic [19:0] buff_size,
   output logic [19:0] buff_addr,
   output logic        buff_rd,
   input  logic        buff_ready,
   input  logic [7:0]  buff_din,
   output logic        tape_out,
   output logic        active,
   output logic        done
);

   localparam int unsigned DIV_W = (CE_PER_SAMPLE > 1) ? $clog2(CE_PER_SAMPLE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_PER_SAMPLE - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExt,
      StRun,
      StDone
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] divider;
   logic [31:0]      count;
   logic             pending;
   logic [1:0]       ext_step;
   logic             held;
   logic [7:0]       held_byte;

   logic        fetching;
   logic        timing;
   logic        sample_tick;
   logic        byte_valid;
   logic        pend_eff;
   logic [7:0]  cur_byte;
   logic [19:0] addr_next;
   logic [19:0] addr_after;
   logic [31:0] ext_count;
   logic [31:0] load_src;
   logic [31:0] load_count;

   always_comb begin
      fetching    = (state == StFetch) || (state == StExt);
      timing      = fetching || (state == StRun);
      sample_tick = play && ce && timing && (divider == DIV_LAST);
      // A byte is consumed either straight off the bus or from the pause buffer.
      byte_valid  = play && fetching && (held || (buff_rd && buff_ready));
      cur_byte    = held ? held_byte : buff_din;
      addr_next   = buff_addr + 20'd1;
      addr_after  = held ? buff_addr : addr_next;
      ext_count   = count | ({24'd0, cur_byte} << {ext_step, 3'b000});
      load_src    = (state == StFetch) ? {24'd0, cur_byte} : ext_count;
      pend_eff    = pending || sample_tick;
      if (!pend_eff) begin
         load_count = load_src;
      end else if (load_src > 32'd1) begin
         load_count = load_src - 32'd1;
      end else begin
         load_count = 32'd1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         buff_addr <= '0;
         buff_rd   <= 1'b0;
         tape_out  <= 1'b0;
         active    <= 1'b0;
         done      <= 1'b0;
         divider   <= '0;
         count     <= '0;
         pending   <= 1'b0;
         ext_step  <= '0;
         held      <= 1'b0;
         held_byte <= '0;
      end else if (rewind) begin
         state     <= StIdle;
         buff_addr <= '0;
         buff_rd   <= 1'b0;
         tape_out  <= 1'b0;
         active    <= 1'b0;
         done      <= 1'b0;
         divider   <= '0;
         count     <= '0;
         pending   <= 1'b0;
         ext_step  <= '0;
         held      <= 1'b0;
      end else begin
         if (play && ce && timing) begin
            divider <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
         end
         if (sample_tick && fetching) begin
            pending <= 1'b1;
         end
         // A read that lands while paused is parked until play returns.
         if (!play && fetching && buff_rd && buff_ready) begin
            held      <= 1'b1;
            held_byte <= buff_din;
            buff_rd   <= 1'b0;
            buff_addr <= addr_next;
         end
         if (byte_valid) begin
            held      <= 1'b0;
            buff_rd   <= 1'b0;
            buff_addr <= addr_after;
         end

         case (state)
            StIdle: begin
               if (play) begin
                  if (buff_size == '0) begin
                     state <= StDone;
                     done  <= 1'b1;
                  end else begin
                     state     <= StFetch;
                     active    <= 1'b1;
                     buff_addr <= '0;
                     buff_rd   <= 1'b1;
                  end
               end
            end
            StFetch: begin
               if (byte_valid) begin
                  if (cur_byte != 8'd0) begin
                     count   <= load_count;
                     pending <= 1'b0;
                     state   <= StRun;
                  end else begin
                     count    <= '0;
                     ext_step <= '0;
                     if (addr_after < buff_size) begin
                        state   <= StExt;
                        buff_rd <= 1'b1;
                     end else begin
                        state  <= StDone;
                        active <= 1'b0;
                        done   <= 1'b1;
                     end
                  end
               end
            end
            StExt: begin
               if (byte_valid) begin
                  if (ext_step != 2'd3) begin
                     count    <= ext_count;
                     ext_step <= ext_step + 2'd1;
                     if (addr_after < buff_size) begin
                        buff_rd <= 1'b1;
                     end else begin
                        state  <= StDone;
                        active <= 1'b0;
                        done   <= 1'b1;
                     end
                  end else if (ext_count == '0) begin
                     // Zero-length pulse: no edge, and the pending tick carries over.
                     if (addr_after < buff_size) begin
                        state   <= StFetch;
                        buff_rd <= 1'b1;
                     end else begin
                        state  <= StDone;
                        active <= 1'b0;
                        done   <= 1'b1;
                     end
                  end else begin
                     count   <= load_count;
                     pending <= 1'b0;
                     state   <= StRun;
                  end
               end
            end
            StRun: begin
               if (sample_tick) begin
                  count <= count - 32'd1;
                  if (count == 32'd1) begin
                     tape_out <= ~tape_out;
                     if (buff_addr < buff_size) begin
                        state   <= StFetch;
                        buff_rd <= 1'b1;
                     end else begin
                        state  <= StDone;
                        active <= 1'b0;
                        done   <= 1'b1;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tape_player.sv
// Randomised bench for tape_player: an event-level model predicts every EAR edge,
// the read count and the DONE cycle from the image, ce pattern and read latencies.
module tb_tape_player;

   localparam int unsigned CE = 4;
   localparam int MAXC = 48000;

   logic        clk_sys = 1'b0;
   logic        reset, ce, play, rewind, buff_ready;
   logic [19:0] buff_size, buff_addr;
   logic        buff_rd;
   logic [7:0]  buff_din;
   logic        tape_out, active, done;

   tape_player #(.CE_PER_SAMPLE(CE)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ce         (ce),
      .play       (play),
      .rewind     (rewind),
      .buff_size  (buff_size),
      .buff_addr  (buff_addr),
      .buff_rd    (buff_rd),
      .buff_ready (buff_ready),
      .buff_din   (buff_din),
      .tape_out   (tape_out),
      .active     (active),
      .done       (done)
   );

   always #5 clk_sys = ~clk_sys;

   logic [7:0] mem [0:63];
   int         lat [0:63];
   bit         ce_arr [0:MAXC-1];
   bit         tick_arr [0:MAXC-1];
   int         img_size;
   int         cyc, s_cyc, pause_at, pause_len;
   int         tog_q[$], exp_tog[$], rd_q[$], base_tog[$];
   int         exp_done, exp_nrd, done_cyc, rd_cnt, rw_read, rw_cyc, base_done, rem;
   bit         busy, rw_arm;
   logic       prev_tape;
   int         n_tests = 0;
   int         n_fail = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One clock: observe outputs, act as the buffer memory, drive the next inputs.
   task automatic step();
      @(negedge clk_sys);
      cyc++;
      if (tape_out !== prev_tape) begin
         tog_q.push_back(cyc - 1);
         prev_tape = tape_out;
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      buff_ready = 1'b0;
      buff_din   = 8'($urandom);
      rewind     = 1'b0;
      if (buff_rd !== 1'b1) begin
         busy = 1'b0;
      end else if (!busy) begin
         busy = 1'b1;
         rem  = lat[rd_cnt % 64];
         rd_q.push_back(int'(buff_addr));
         rd_cnt++;
      end else begin
         rem--;
         if (rem == 0) begin
            buff_ready = 1'b1;
            buff_din   = (buff_addr < 64) ? mem[buff_addr[5:0]] : 8'hff;
            busy       = 1'b0;
            if (rw_arm && rd_cnt == rw_read) begin
               rewind = 1'b1;
               rw_arm = 1'b0;
               rw_cyc = cyc;
            end
         end
      end
      ce   = (cyc < MAXC) ? ce_arr[cyc] : 1'b1;
      play = (cyc >= s_cyc) &&
             !(pause_len > 0 && cyc >= pause_at && cyc < pause_at + pause_len);
   endtask

   task automatic begin_test(input int start_at);
      @(negedge clk_sys);
      #2;
      reset = 1'b1; play = 1'b0; rewind = 1'b0; ce = 1'b0; buff_ready = 1'b0;
      buff_size = 20'(img_size);
      #1;
      check("reset_outputs", {buff_addr, buff_rd, tape_out, active, done}, 0);
      @(negedge clk_sys);
      @(negedge clk_sys);
      reset = 1'b0;
      cyc = 0; s_cyc = start_at; pause_at = 0; pause_len = 0;
      tog_q.delete(); rd_q.delete();
      rd_cnt = 0; busy = 1'b0; done_cyc = -1; prev_tape = 1'b0; rw_arm = 1'b0;
   endtask

   // Event-level model: sample ticks are every CE-th ce since playback started;
   // each read takes its latency plus one issue cycle; pulses end on the M-th tick.
   task automatic run_model();
      int cnt, t, addr, j, p, pend_from, m, n, c, hits;
      longint unsigned ext;
      bit pend;
      exp_tog.delete(); exp_done = -1; exp_nrd = 0;
      cnt = 0;
      for (int k = 0; k < MAXC; k++) begin
         tick_arr[k] = 1'b0;
         if (k > s_cyc && ce_arr[k]) begin
            cnt++;
            if (cnt == CE) begin tick_arr[k] = 1'b1; cnt = 0; end
         end
      end
      if (img_size == 0) begin exp_done = s_cyc + 1; return; end
      t = s_cyc + 1; addr = 0; j = 0; pend_from = t;
      forever begin
         p = t + lat[j]; j++; exp_nrd = j;
         n = int'(mem[addr]); addr++;
         if (n == 0) begin
            ext = 0;
            for (int k = 0; k < 4; k++) begin
               if (addr >= img_size) begin exp_done = p + 1; return; end
               p = p + 1 + lat[j]; j++; exp_nrd = j;
               ext |= longint'(mem[addr]) << (8 * k); addr++;
            end
            if (ext == 0) begin
               if (addr >= img_size) begin exp_done = p + 1; return; end
               t = p + 1;
               continue;
            end
            n = int'(ext);
         end
         pend = 1'b0;
         for (int k = pend_from; k <= p; k++) if (tick_arr[k]) pend = 1'b1;
         m = pend ? ((n > 1) ? n - 1 : 1) : n;
         c = p + 1; hits = 0;
         while (c < MAXC) begin
            if (tick_arr[c]) hits++;
            if (hits == m) break;
            c++;
         end
         if (c >= MAXC) begin exp_done = -2; return; end
         exp_tog.push_back(c);
         if (addr >= img_size) begin exp_done = c + 1; return; end
         t = c + 1; pend_from = t;
      end
   endtask

   task automatic run_to_end();
      int bound;
      bound = (exp_done > 0) ? exp_done + 12 : MAXC - 8;
      while (cyc < bound) step();
   endtask

   task automatic finish_run(input string tag);
      int bad;
      check({tag, "_ntoggles"}, tog_q.size(), exp_tog.size());
      for (int i = 0; i < tog_q.size() && i < exp_tog.size(); i++)
         check({tag, "_toggle_cycle"}, tog_q[i], exp_tog[i]);
      check({tag, "_done_cycle"}, done_cyc, exp_done);
      check({tag, "_done_active"}, {done, active}, 2'b10);
      check({tag, "_tape_level"}, tape_out, exp_tog.size() % 2);
      check({tag, "_nreads"}, rd_cnt, exp_nrd);
      bad = -1;
      foreach (rd_q[i]) if (rd_q[i] != i && bad < 0) bad = i;
      check({tag, "_first_bad_addr_idx"}, bad, -1);
   endtask

   task automatic load5(input int len, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
      mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3; mem[4] = b4;
      img_size = len;
   endtask

   task automatic fill_ce(input bit rnd);
      for (int k = 0; k < MAXC; k++) ce_arr[k] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
   endtask

   task automatic fill_lat(input bit rnd);
      for (int k = 0; k < 64; k++) lat[k] = rnd ? int'($urandom_range(1, 3)) : 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int len, first_rel;
      for (int k = 0; k < 64; k++) mem[k] = 8'h00;

      // {02,03}: edges 8 and then 12 ticks after start.
      fill_ce(0); fill_lat(0); load5(2, 8'h02, 8'h03, 0, 0, 0);
      begin_test(5); run_model();
      while (cyc < 4) step();
      check("idle_hold", {buff_rd, active, done}, 0);
      run_to_end(); finish_run("img_0203");
      if (tog_q.size() >= 2) begin
         check("img_0203_first_edge", tog_q[0] - s_cyc, 8);
         check("img_0203_second_edge", tog_q[1] - tog_q[0], 12);
      end
      base_tog = tog_q; base_done = done_cyc;

      // Pause for 100 cycles mid-RUN shifts everything by 100.
      begin_test(5); pause_at = base_tog[0] - 3; pause_len = 100;
      while (cyc < base_done + 110) step();
      check("pause_ntoggles", tog_q.size(), base_tog.size());
      for (int i = 0; i < tog_q.size() && i < base_tog.size(); i++)
         check("pause_toggle_shift", tog_q[i] - base_tog[i], 100);
      check("pause_done_shift", done_cyc - base_done, 100);

      // Pause while a read is outstanding: it completes, nothing new issues.
      fill_lat(0); lat[0] = 3; load5(5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
      begin_test(2); pause_at = 4; pause_len = 20;
      while (cyc < 23) step();
      check("pause_rd_reads", rd_cnt, 1);
      check("pause_rd_dropped", buff_rd, 0);
      check("pause_rd_addr", buff_addr, 1);
      while (cyc < 300) step();
      check("pause_rd_ntoggles", tog_q.size(), 1);
      check("pause_rd_done", done, 1);

      // Extended count 10000, all-zero extended count, truncated image, empty image.
      fill_lat(0);
      load5(5, 8'h00, 8'h10, 8'h27, 8'h00, 8'h00);
      begin_test(3); run_model(); run_to_end(); finish_run("ext_10000");
      check("ext_10000_model_edges", exp_tog.size(), 1);
      load5(5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      begin_test(3); run_model(); run_to_end(); finish_run("ext_zero");
      check("ext_zero_edges", tog_q.size(), 0);
      load5(2, 8'h00, 8'h05, 0, 0, 0);
      begin_test(3); run_model(); run_to_end(); finish_run("truncated");
      check("truncated_reads", rd_cnt, 2);
      load5(0, 0, 0, 0, 0, 0);
      begin_test(4); run_model(); run_to_end(); finish_run("empty");
      check("empty_done_next", done_cyc, 5);

      // Rewind on the same cycle as the second read's ready, then replay.
      load5(2, 8'h02, 8'h03, 0, 0, 0);
      begin_test(2); rw_arm = 1'b1; rw_read = 2;
      while (rw_arm && cyc < 200) step();
      check("rewind_fired", rw_arm, 0);
      first_rel = (tog_q.size() > 0) ? tog_q[0] - s_cyc : -1;
      step();
      check("rewind_addr", buff_addr, 0);
      check("rewind_tape", tape_out, 0);
      check("rewind_rd_active", {buff_rd, active, done}, 0);
      s_cyc = rw_cyc + 1; run_model();
      tog_q.delete(); rd_q.delete(); rd_cnt = 0; done_cyc = -1; busy = 1'b0;
      run_to_end(); finish_run("replay");
      if (tog_q.size() > 0) check("replay_first_edge", tog_q[0] - s_cyc, first_rel);

      // Randomised images, ce density and read latency.
      for (int r = 0; r < 20; r++) begin
         len = 0;
         for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
            if ($urandom_range(0, 3) == 0) begin
               mem[len] = 8'h00; mem[len+1] = 8'($urandom_range(0, 10));
               mem[len+2] = 8'h00; mem[len+3] = 8'h00; mem[len+4] = 8'h00;
               len += 5;
            end else begin
               mem[len] = 8'($urandom_range(1, 6)); len++;
            end
         end
         img_size = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : len;
         fill_ce($urandom_range(0, 1) == 1); fill_lat(1);
         begin_test(int'($urandom_range(1, 6))); run_model(); run_to_end();
         finish_run("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
